top_accumulator: RTL and testbench
==================================

TOP_ACCUMULATOR -- requirements
Module: top

Interface
REQ-001 Parameter BITS, default 32, operand width in bits (legal range 1..32).
REQ-002 Parameter CGES, default 49, number of operands summed per run (CGES >= 1).
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-high reset; the name is historical, and 1 resets the block.
REQ-005 Port start, input, 1, level-sensitive run request, sampled only in IDLE.
REQ-006 Port fin, input, 1, level-sensitive acknowledge, sampled only in DONE.
REQ-007 Port result, output, $clog2(CGES)+BITS, registered sum of the last completed run.

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-009 IDLE: start=1 -> RUN on the next edge; accumulator and operand index k cleared to 0 on that edge.
REQ-010 IDLE: start=0 -> remain in IDLE.
REQ-011 RUN: each cycle, accumulator += operand(k) and k increments; this gives one operand per clock.
REQ-012 Operand(k) SHALL be k+1, zero-extended/truncated to BITS bits, for k = 0..CGES-1.
REQ-013 RUN: the cycle that adds operand(CGES-1) SHALL move to DONE and load result with the final sum on the same edge.
REQ-014 Latency: result becomes valid exactly CGES+1 rising edges after the edge that samples start=1 in IDLE.
REQ-015 DONE: fin=1 -> IDLE on the next edge; result retained.
REQ-016 DONE: fin=0 -> remain in DONE; result stable.
REQ-017 fin SHALL be ignored in IDLE and RUN, and start SHALL be ignored in RUN and DONE.
REQ-018 Start held high continuously SHALL restart a new run one edge after each return to IDLE.
REQ-019 Accumulator width equals result width; the sum never overflows for legal parameters, and no saturation logic is needed.
REQ-020 result SHALL change only on entry to DONE or on reset; it is never written with partial sums.

Reset
REQ-021 reset_n=1 SHALL asynchronously force state=IDLE, k=0, accumulator=0, result=0.
REQ-022 Reset asserted mid-RUN SHALL abort the run, and result reads 0 immediately.
REQ-023 After reset_n falls, the first start=1 sampled SHALL begin a run normally.

Structure
REQ-024 Shared package top_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default BITS/CGES constants.
REQ-025 Operand generation (index counter plus k+1 mapping, terminal-count flag) SHALL live in one sub-module, cge_source.
REQ-026 top SHALL contain the FSM, the accumulator and the result register, and instantiate cge_source.

Verification
REQ-027 Reset 1 for 1 cycle, then 0 with start=1, fin=0 -> result=0 through RUN; result=1225 (0x4C9) on the 50th edge after start is sampled, then stable.
REQ-028 start held 1 for 1000 cycles, fin=0 -> result stays 1225, with exactly one run and no restart while in DONE.
REQ-029 In DONE pulse fin=1 for 1 cycle with start=1 -> IDLE, new run starts, and result holds 1225 throughout and is reloaded with 1225.
REQ-030 Assert reset_n at cycle 20 of RUN -> result=0 and state=IDLE asynchronously; after release, a new run yields 1225.
REQ-031 CGES=1, BITS=8 -> result=1 two edges after start is sampled, and result width is 8.
REQ-032 fin=1 throughout IDLE and RUN -> no effect, and the normal 1225 result is reached.

Source files
------------

// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared state type and default sizing for top_accumulator
//
// Purpose: common definitions imported by top_accumulator and cge_source.
//   state_t  : run-control FSM states (IDLE, RUN, DONE)
//   DEF_BITS : default operand width in bits
//   DEF_CGES : default number of operands summed per run
package top_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_BITS = 32;
  localparam int DEF_CGES = 49;

endpackage

// File: rtl/cge_source.sv
// rtl/cge_source.sv - operand generator: index counter, k+1 mapping, terminal flag
//
// Purpose: issues operand(k) = k+1 (truncated/zero-extended to BITS) for
// k = 0..CGES-1, one per clock while enabled. The operand is registered, so
// it is presented one cycle after the index that produced it.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   clear   : synchronous restart of the sequence at k = 0
//   enable  : advance one operand per clock
//   operand : registered operand value
//   valid   : operand holds a fresh value this cycle
//   last    : operand is operand(CGES-1)
module cge_source
  import top_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int CGES = DEF_CGES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  output logic [BITS-1:0] operand,
  output logic            valid,
  output logic            last
);

  // Index must be able to hold CGES itself, the "sequence exhausted" value.
  localparam int KW = $clog2(CGES + 1);
  localparam logic [KW-1:0] K_END  = KW'(CGES);
  localparam logic [KW-1:0] K_LAST = KW'(CGES - 1);

  logic [KW-1:0] k;
  logic [KW:0]   k_plus1;
  logic          adv;

  // Once all CGES operands are issued the counter parks at K_END, so a late
  // enable cycle cannot produce a spurious extra operand.
  assign adv     = enable && (k != K_END);
  assign k_plus1 = {1'b0, k} + {{KW{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      operand <= '0;
      valid   <= 1'b0;
      last    <= 1'b0;
    end else if (clear) begin
      k     <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else begin
      valid <= adv;
      last  <= adv && (k == K_LAST);
      if (adv) begin
        operand <= BITS'(k_plus1);
        k       <= k_plus1[KW-1:0];
      end
    end
  end

endmodule

// File: rtl/top_accumulator.sv
// rtl/top_accumulator.sv - run-controlled accumulator of the series 1..CGES
//
// Purpose: on a start request, sums CGES generated operands (one per clock)
// and loads the final sum into a result register, which holds until the
// next completed run or reset.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous reset, ACTIVE HIGH despite the historical name
//   start   : run request, sampled only in IDLE
//   fin     : acknowledge, sampled only in DONE
//   result  : registered sum of the last completed run ($clog2(CGES)+BITS bits)
module top_accumulator
  import top_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int CGES = DEF_CGES
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          fin,
  output logic [$clog2(CGES)+BITS-1:0]  result
);

  localparam int RW = $clog2(CGES) + BITS;

  state_t          state, state_nx;
  logic            src_clear, src_en;
  logic [BITS-1:0] op;
  logic            op_valid, op_last;
  logic [RW-1:0]   acc, acc_sum;
  logic            run_start, run_add, run_end;

  cge_source #(
    .BITS(BITS),
    .CGES(CGES)
  ) u_src (
    .clk    (clk),
    .rst    (reset_n),
    .clear  (src_clear),
    .enable (src_en),
    .operand(op),
    .valid  (op_valid),
    .last   (op_last)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    src_clear = 1'b0;
    src_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = RUN;
          src_clear = 1'b1;
        end
      end
      RUN: begin
        src_en = 1'b1;
        if (op_valid && op_last) state_nx = DONE;
      end
      DONE: begin
        if (fin) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign run_start = (state == IDLE) && start;
  assign run_add   = (state == RUN) && op_valid;
  assign run_end   = run_add && op_last;
  assign acc_sum   = acc + RW'(op);

  // result is written only with the completed sum, never a partial one.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (run_start)    acc <= '0;
      else if (run_add) acc <= acc_sum;
      if (run_end) result <= acc_sum;
    end
  end

endmodule

// File: tb/tb_top_accumulator.sv
// tb/tb_top_accumulator.sv - scoreboard bench for top_accumulator
module tb_top_accumulator;

  localparam int BITS   = 32;
  localparam int CGES   = 49;
  localparam int RW     = $clog2(CGES) + BITS;
  localparam int S_BITS = 8;
  localparam int S_CGES = 1;
  localparam int S_RW   = $clog2(S_CGES) + S_BITS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, start, fin, start_s, fin_s;
  logic [RW-1:0]   result;
  logic [S_RW-1:0] result_s;

  top_accumulator #(.BITS(BITS), .CGES(CGES)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .fin(fin), .result(result)
  );

  top_accumulator #(.BITS(S_BITS), .CGES(S_CGES)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start_s), .fin(fin_s), .result(result_s)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] run_sum(input int n, input int b);
    logic [63:0] s;
    logic [63:0] mask;
    s    = 64'd0;
    mask = (64'd1 << b) - 64'd1;
    for (int k = 1; k <= n; k++) s += 64'(k) & mask;
    return s;
  endfunction

  typedef struct {
    longint      due;
    logic [63:0] val;
  } sb_t;

  sb_t         sb[$];
  longint      cyc     = 0;
  int          m_state = 0;
  int          m_cnt   = 0;
  logic [63:0] m_res   = 64'd0;
  bit          check_en = 1'b0;

  // Timing model: a sampled start schedules the expected sum CGES+1 edges later.
  always @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      m_state = 0;
      m_cnt   = 0;
      m_res   = 64'd0;
      sb.delete();
    end else begin
      cyc++;
      case (m_state)
        0: if (start) begin
          m_state = 1;
          m_cnt   = 0;
          sb.push_back('{due: cyc + CGES + 1, val: run_sum(CGES, BITS)});
        end
        1: begin
          m_cnt++;
          if (m_cnt == CGES + 1) m_state = 2;
        end
        default: if (fin) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check_value("sum_at_due", 64'(result), sb[0].val);
        m_res = sb[0].val;
        sb.delete(0);
      end else begin
        check_value("result_hold", 64'(result), m_res);
      end
    end
  end

  initial begin
    reset_n = 1'b1; start = 1'b0; fin = 1'b0; start_s = 1'b0; fin_s = 1'b0;
    repeat (2) @(negedge clk);
    check_value("reset_result", 64'(result), 64'd0);
    check_value("reset_result_s", 64'(result_s), 64'd0);
    check_en = 1'b1;

    // start held high: one run, no restart while parked in DONE
    #1 reset_n = 1'b0; start = 1'b1; fin = 1'b0;
    repeat (1000) @(negedge clk);

    // one-cycle fin with start still high: back to IDLE, immediate new run
    #1 fin = 1'b1;
    @(negedge clk);
    #1 fin = 1'b0;
    repeat (60) @(negedge clk);

    // fin high through IDLE and RUN must not disturb a run
    #1 start = 1'b0; fin = 1'b1;
    repeat (3) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    repeat (60) @(negedge clk);

    // reset in the middle of a run
    #1 fin = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 check_value("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    repeat (60) @(negedge clk);
    #1 start = 1'b0; fin = 1'b1;
    repeat (3) @(negedge clk);
    #1 fin = 1'b0;
    repeat (2) @(negedge clk);

    // single-operand instance: result = 1 two edges after start is sampled
    #1 start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    @(negedge clk);
    check_value("s_edge0", 64'(result_s), 64'd0);
    @(negedge clk);
    check_value("s_edge1", 64'(result_s), 64'd0);
    @(negedge clk);
    check_value("s_edge2", 64'(result_s), run_sum(S_CGES, S_BITS));
    repeat (3) @(negedge clk);
    check_value("s_hold", 64'(result_s), run_sum(S_CGES, S_BITS));

    check_en = 1'b0;
    check_value("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
